// File: rtl/alarm_ctrl.sv
// Alarm sequencer: watches the running time against the stored alarm time,
// drives the beeper enable/reset, and handles stop, snooze, auto-snooze on
// an unanswered 60 s beep window, and a per-event snooze limit.
module alarm_ctrl #(
  parameter int SNOOZE_SEC = 300,  // snooze delay in seconds (1..1023)
  parameter int MAX_SNOOZE = 3     // snoozes allowed per alarm event (1..7)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1s,
  input  logic [4:0] cur_hour,
  input  logic [5:0] cur_min,
  input  logic [5:0] cur_sec,
  input  logic [4:0] alm_hour,
  input  logic [5:0] alm_min,
  input  logic       alarm_en,
  input  logic       stop_btn,
  input  logic       snooze_btn,
  input  logic       beep_done,
  output logic       beep_on,
  output logic       beep_rst,
  output logic [1:0] state,
  output logic [2:0] snooze_cnt,
  output logic       missed
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ARMED    = 2'd1,
    S_RINGING  = 2'd2,
    S_SNOOZING = 2'd3
  } state_t;

  localparam logic [9:0] SNOOZE_LOAD = 10'(SNOOZE_SEC);
  localparam logic [2:0] SNOOZE_MAX  = 3'(MAX_SNOOZE);

  state_t      state_q, state_d;
  logic [9:0]  timer_q, timer_d;
  logic [2:0]  snooze_cnt_d;
  logic        missed_d;
  logic        beep_on_d;
  logic        beep_rst_d;
  logic        match;
  logic        can_snooze;

  // Seconds are zero only once per minute, so a match can fire at most once.
  assign match      = tick_1s && (cur_hour == alm_hour) && (cur_min == alm_min) &&
                      (cur_sec == 6'd0);
  assign can_snooze = (snooze_cnt < SNOOZE_MAX);

  // Next-state and next-output logic; priority is disarm > stop > snooze > beep_done > timer/match.
  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    snooze_cnt_d = snooze_cnt;
    missed_d     = missed;

    // Disarming or stopping always clears the missed flag, whatever the state.
    if (!alarm_en || stop_btn) begin
      missed_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (alarm_en) begin
          state_d = S_ARMED;
        end
      end

      S_ARMED: begin
        if (!alarm_en) begin
          state_d = S_IDLE;
        end else if (stop_btn) begin
          state_d = S_ARMED;
        end else if (match) begin
          state_d      = S_RINGING;
          snooze_cnt_d = 3'd0;
        end
      end

      S_RINGING: begin
        if (!alarm_en) begin
          state_d      = S_IDLE;
          snooze_cnt_d = 3'd0;
        end else if (stop_btn) begin
          state_d      = S_ARMED;
          snooze_cnt_d = 3'd0;
        end else if ((snooze_btn || beep_done) && can_snooze) begin
          // A press and an expiring beep window together count as one snooze.
          state_d      = S_SNOOZING;
          timer_d      = SNOOZE_LOAD;
          snooze_cnt_d = snooze_cnt + 3'd1;
        end else if (beep_done) begin
          // Limit reached and nobody answered: give up on this event.
          state_d      = S_ARMED;
          missed_d     = 1'b1;
          snooze_cnt_d = 3'd0;
        end
      end

      S_SNOOZING: begin
        if (!alarm_en) begin
          state_d      = S_IDLE;
          timer_d      = 10'd0;
          snooze_cnt_d = 3'd0;
        end else if (stop_btn) begin
          state_d      = S_ARMED;
          timer_d      = 10'd0;
          snooze_cnt_d = 3'd0;
        end else if (tick_1s) begin
          if (timer_q <= 10'd1) begin
            timer_d = 10'd0;
            state_d = S_RINGING;
          end else begin
            timer_d = timer_q - 10'd1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    beep_on_d  = (state_d == S_RINGING);
    beep_rst_d = (state_d == S_RINGING) && (state_q != S_RINGING);
  end

  // State and output registers; reset silences the beeper immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      timer_q    <= 10'd0;
      snooze_cnt <= 3'd0;
      missed     <= 1'b0;
      beep_on    <= 1'b0;
      beep_rst   <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      snooze_cnt <= snooze_cnt_d;
      missed     <= missed_d;
      beep_on    <= beep_on_d;
      beep_rst   <= beep_rst_d;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Bench for alarm_ctrl: scenario tasks push the expected output word for
// every driven cycle into a scoreboard queue and pop it once the DUT responds.
module tb_alarm_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick_1s = 1'b0;
  logic [4:0] cur_hour = 5'd0;
  logic [5:0] cur_min = 6'd0;
  logic [5:0] cur_sec = 6'd0;
  logic [4:0] alm_hour = 5'd7;
  logic [5:0] alm_min = 6'd0;
  logic       alarm_en = 1'b0;
  logic       stop_btn = 1'b0;
  logic       snooze_btn = 1'b0;
  logic       beep_done = 1'b0;
  logic       beep_on;
  logic       beep_rst;
  logic [1:0] state;
  logic [2:0] snooze_cnt;
  logic       missed;

  alarm_ctrl #(.SNOOZE_SEC(300), .MAX_SNOOZE(3)) dut (
    .clk(clk), .reset(reset), .tick_1s(tick_1s),
    .cur_hour(cur_hour), .cur_min(cur_min), .cur_sec(cur_sec),
    .alm_hour(alm_hour), .alm_min(alm_min), .alarm_en(alarm_en),
    .stop_btn(stop_btn), .snooze_btn(snooze_btn), .beep_done(beep_done),
    .beep_on(beep_on), .beep_rst(beep_rst), .state(state),
    .snooze_cnt(snooze_cnt), .missed(missed)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] val;
    logic [7:0] mask;
  } exp_t;

  typedef struct packed {
    logic       en, stp, snz, done, tk;
    logic [4:0] hh;
    logic [5:0] mm, ss;
    logic [7:0] val, mask;
  } row_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Expected output word: {state, beep_on, beep_rst, snooze_cnt, missed}
  function automatic logic [7:0] ex(int st, int on, int rst, int cnt, int ms);
    return {st[1:0], on[0], rst[0], cnt[2:0], ms[0]};
  endfunction

  function automatic logic [7:0] obs();
    return {state, beep_on, beep_rst, snooze_cnt, missed};
  endfunction

  function automatic row_t r(logic en, logic stp, logic snz, logic done, logic tk,
                             int hh, int mm, int ss, logic [7:0] val,
                             logic [7:0] mask = 8'hFF);
    row_t x;
    x.en = en; x.stp = stp; x.snz = snz; x.done = done; x.tk = tk;
    x.hh = hh[4:0]; x.mm = mm[5:0]; x.ss = ss[5:0];
    x.val = val; x.mask = mask;
    return x;
  endfunction

  // Apply one cycle of stimulus, let the DUT clock it, release the pulses.
  task automatic drive(input row_t x);
    alarm_en = x.en; stop_btn = x.stp; snooze_btn = x.snz;
    beep_done = x.done; tick_1s = x.tk;
    cur_hour = x.hh; cur_min = x.mm; cur_sec = x.ss;
    @(posedge clk);
    #1;
    stop_btn = 1'b0; snooze_btn = 1'b0; beep_done = 1'b0; tick_1s = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    alarm_en = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (obs() !== 8'h00) begin
      errors++;
      $display("FAIL reset_values got %b expected %b", obs(), 8'h00);
    end
    reset = 1'b0;
    exp_q.push_back(exp_t'{ex(1, 0, 0, 0, 0), 8'hFF});
    drive(r(1, 0, 0, 0, 0, 6, 0, 0, ex(1, 0, 0, 0, 0)));
    e = exp_q.pop_front();
    checks++;
    if (obs() !== e.val) begin
      errors++;
      $display("FAIL reset_arm got %b expected %b", obs(), e.val);
    end
  endtask

  task automatic test_ring(input logic ms);
    row_t rows[$];
    exp_t e;
    rows.push_back(r(1, 0, 0, 0, 1, 6, 59, 59, ex(1, 0, 0, 0, ms)));
    rows.push_back(r(1, 0, 0, 0, 1, 7, 0, 0, ex(2, 1, 1, 0, ms)));
    rows.push_back(r(1, 0, 0, 0, 0, 7, 0, 0, ex(2, 1, 0, 0, ms)));
    rows.push_back(r(1, 0, 0, 0, 1, 7, 0, 1, ex(2, 1, 0, 0, ms)));
    foreach (rows[i]) begin
      exp_q.push_back(exp_t'{rows[i].val, rows[i].mask});
      drive(rows[i]);
      e = exp_q.pop_front();
      checks++;
      if ((obs() & e.mask) !== (e.val & e.mask)) begin
        errors++;
        $display("FAIL ring[%0d] got %b expected %b", i, obs(), e.val);
      end
    end
  endtask

  // One snooze (button or beep_done) followed by the full 300 s countdown.
  task automatic test_snooze_round(input logic use_done, input int cnt, input logic ms);
    row_t rows[$];
    exp_t e;
    rows.push_back(r(1, 0, !use_done, use_done, 0, 7, 0, 5, ex(3, 0, 0, cnt, ms)));
    for (int k = 1; k <= 300; k++) begin
      if (k < 300) rows.push_back(r(1, 0, 0, 0, 1, 7, 0, 5, ex(3, 0, 0, cnt, ms)));
      else         rows.push_back(r(1, 0, 0, 0, 1, 7, 0, 5, ex(2, 1, 1, cnt, ms)));
    end
    rows.push_back(r(1, 0, 0, 0, 0, 7, 0, 5, ex(2, 1, 0, cnt, ms)));
    foreach (rows[i]) begin
      exp_q.push_back(exp_t'{rows[i].val, rows[i].mask});
      drive(rows[i]);
      e = exp_q.pop_front();
      checks++;
      if ((obs() & e.mask) !== (e.val & e.mask)) begin
        errors++;
        $display("FAIL snooze_round[%0d] cnt %0d got %b expected %b", i, cnt, obs(), e.val);
      end
    end
  endtask

  task automatic test_snooze();
    row_t x;
    exp_t e;
    test_ring(1'b0);
    test_snooze_round(1'b0, 1, 1'b0);
    x = r(1, 1, 0, 0, 0, 7, 0, 5, ex(1, 0, 0, 0, 0));
    exp_q.push_back(exp_t'{x.val, x.mask});
    drive(x);
    e = exp_q.pop_front();
    checks++;
    if (obs() !== e.val) begin
      errors++;
      $display("FAIL snooze_stop got %b expected %b", obs(), e.val);
    end
  endtask

  task automatic test_auto_snooze();
    row_t x;
    exp_t e;
    test_ring(1'b0);
    for (int j = 1; j <= 3; j++) test_snooze_round(1'b1, j, 1'b0);
    x = r(1, 0, 0, 1, 0, 7, 0, 5, ex(1, 0, 0, 0, 1));
    exp_q.push_back(exp_t'{x.val, x.mask});
    drive(x);
    e = exp_q.pop_front();
    checks++;
    if (obs() !== e.val) begin
      errors++;
      $display("FAIL auto_snooze_exhaust got %b expected %b", obs(), e.val);
    end
  endtask

  task automatic test_snooze_limit();
    row_t rows[$];
    exp_t e;
    test_ring(1'b1);
    for (int j = 1; j <= 3; j++) test_snooze_round(1'b0, j, 1'b1);
    rows.push_back(r(1, 0, 1, 0, 0, 7, 0, 5, ex(2, 1, 0, 3, 1)));
    rows.push_back(r(1, 1, 0, 0, 0, 7, 0, 5, ex(1, 0, 0, 0, 0)));
    foreach (rows[i]) begin
      exp_q.push_back(exp_t'{rows[i].val, rows[i].mask});
      drive(rows[i]);
      e = exp_q.pop_front();
      checks++;
      if ((obs() & e.mask) !== (e.val & e.mask)) begin
        errors++;
        $display("FAIL snooze_limit[%0d] got %b expected %b", i, obs(), e.val);
      end
    end
  endtask

  task automatic test_back_to_back();
    row_t rows[$];
    exp_t e;
    test_ring(1'b0);
    // stop and snooze together: stop wins
    rows.push_back(r(1, 1, 1, 0, 0, 7, 0, 2, ex(1, 0, 0, 0, 0)));
    // ring again next minute-match, then snooze
    rows.push_back(r(1, 0, 0, 0, 1, 7, 0, 0, ex(2, 1, 1, 0, 0)));
    rows.push_back(r(1, 0, 1, 0, 0, 7, 0, 0, ex(3, 0, 0, 1, 0)));
    // match while snoozing does not re-trigger
    rows.push_back(r(1, 0, 0, 0, 1, 7, 0, 0, ex(3, 0, 0, 1, 0)));
    // disarm while snoozing
    rows.push_back(r(0, 0, 0, 0, 0, 7, 0, 3, ex(0, 0, 0, 0, 0), 8'hF1));
    rows.push_back(r(0, 0, 0, 0, 1, 7, 0, 0, ex(0, 0, 0, 0, 0), 8'hF1));
    // re-enable, then a match rings again
    rows.push_back(r(1, 0, 0, 0, 0, 7, 0, 3, ex(1, 0, 0, 0, 0), 8'hF1));
    rows.push_back(r(1, 0, 0, 0, 1, 7, 0, 0, ex(2, 1, 1, 0, 0)));
    rows.push_back(r(1, 0, 0, 0, 0, 7, 0, 0, ex(2, 1, 0, 0, 0)));
    foreach (rows[i]) begin
      exp_q.push_back(exp_t'{rows[i].val, rows[i].mask});
      drive(rows[i]);
      e = exp_q.pop_front();
      checks++;
      if ((obs() & e.mask) !== (e.val & e.mask)) begin
        errors++;
        $display("FAIL back_to_back[%0d] got %b expected %b", i, obs(), e.val);
      end
    end
  endtask

  task automatic test_reset_mid_ring();
    row_t x;
    exp_t e;
    // still RINGING from the previous task
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (beep_on !== 1'b0 || state !== 2'd0) begin
      errors++;
      $display("FAIL async_reset got beep_on=%b state=%0d expected beep_on=0 state=0",
               beep_on, state);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    x = r(1, 0, 0, 0, 0, 7, 0, 9, ex(1, 0, 0, 0, 0));
    exp_q.push_back(exp_t'{x.val, x.mask});
    drive(x);
    e = exp_q.pop_front();
    checks++;
    if (obs() !== e.val) begin
      errors++;
      $display("FAIL reset_rearm got %b expected %b", obs(), e.val);
    end
  endtask

  initial begin
    test_reset();
    test_snooze();
    test_auto_snooze();
    test_snooze_limit();
    test_back_to_back();
    test_reset_mid_ring();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
